// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// Entry layouts are sized from the package defaults (N_IN=4, N_OUT=6, N_REQ=4).
package mult_share_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 6;

  // Index width for a requester count; a single requester still gets one bit.
  function automatic int id_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

  localparam int ID_W_DEF = id_w(N_REQ_DEF);

  // Operand stage: who asked, and the two operands feeding the datapath.
  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [N_IN_DEF-1:0]  a;
    logic [N_IN_DEF-1:0]  b;
  } s1_entry_t;

  // Result stage: who asked, and the datapath output.
  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [N_OUT_DEF-1:0] result;
  } s2_entry_t;

endpackage

// File: rtl/mult_share_rr_arb.sv
// Requester arbiter for the shared multiplier.
// Default: round-robin starting at a pointer that moves past each winner.
// With MULT_SHARE_ARBITER_FIXED_PRIO_EN defined: lowest index wins and no
// pointer register exists.
module mult_share_rr_arb #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk_ci,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [ID_W-1:0] start_s;
  logic [ID_W:0]   cand_s;
  logic [ID_W-1:0] idx_s;
  logic            found_s;

`ifdef MULT_SHARE_ARBITER_FIXED_PRIO_EN
  assign start_s = '0;
`else
  logic [ID_W-1:0] ptr_r;

  // Pointer moves to one past the winner on every handshake, else holds.
  always_ff @(posedge clk_ci) begin
    if (rst_i) begin
      ptr_r <= '0;
    end else if (gnt_valid_o) begin
      if (idx_s == ID_W'(N_REQ - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= idx_s + ID_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign start_s = ptr_r;
`endif

  // Circular search for the first active request at or after the start index.
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = {1'b0, start_s} + (ID_W+1)'(k);
      if (cand_s >= (ID_W+1)'(N_REQ)) begin
        cand_s = cand_s - (ID_W+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_i[cand_s[ID_W-1:0]]) begin
        found_s = 1'b1;
        idx_s   = cand_s[ID_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant only when the operand stage can take a new entry.
  always_comb begin
    gnt_o = '0;
    if (en_i && found_s) begin
      gnt_o[idx_s] = 1'b1;
    end else begin
      gnt_o = '0;
    end
  end

  assign gnt_idx_o   = idx_s;
  assign gnt_valid_o = en_i & found_s;

endmodule

// File: rtl/mydesign_comb.sv
// Combinational multiplier datapath: result = (a * b) mod 2^N_OUT.
module mydesign_comb #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 6
) (
  input  logic [N_IN-1:0]  a_i,
  input  logic [N_IN-1:0]  b_i,
  output logic [N_OUT-1:0] result_o
);

  logic [N_OUT-1:0] a_ext_s;
  logic [N_OUT-1:0] b_ext_s;

  // Working at N_OUT bits keeps exactly the low N_OUT bits of the product.
  assign a_ext_s  = N_OUT'(a_i);
  assign b_ext_s  = N_OUT'(b_i);
  assign result_o = a_ext_s * b_ext_s;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier between N_REQ valid/ready requesters.
// Pipeline: arbiter -> S1 operand register -> mydesign_comb -> S2 result
// register -> tagged response channel. One operation per cycle at full rate.
// Arbitration mode is selected by MULT_SHARE_ARBITER_FIXED_PRIO_EN (see
// mult_share_rr_arb); ports and latency are the same in both modes.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic                  clk_ci,
  input  logic                  rst_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  output logic [N_REQ-1:0]      req_ready_o,
  input  logic [N_REQ*N_IN-1:0] req_a_i,
  input  logic [N_REQ*N_IN-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic [N_OUT-1:0]      rsp_result_o
);

  s1_entry_t       s1_r;
  s2_entry_t       s2_r;
  logic            s1_valid_r;
  logic            s2_valid_r;
  logic            s1_adv_s;
  logic            s2_adv_s;
  logic            arb_en_s;
  logic [N_REQ-1:0] gnt_s;
  logic [ID_W-1:0] gnt_idx_s;
  logic            gnt_valid_s;
  logic [N_OUT-1:0] dp_result_s;

  // Each stage moves when its successor has room; the response consumer
  // frees S2. No grants are issued while reset is held.
  assign s2_adv_s = ~s2_valid_r | rsp_ready_i;
  assign s1_adv_s = ~s1_valid_r | s2_adv_s;
  assign arb_en_s = s1_adv_s & ~rst_i;

  mult_share_rr_arb #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk_ci      (clk_ci),
    .rst_i       (rst_i),
    .req_i       (req_valid_i),
    .en_i        (arb_en_s),
    .gnt_o       (gnt_s),
    .gnt_idx_o   (gnt_idx_s),
    .gnt_valid_o (gnt_valid_s)
  );

  assign req_ready_o = gnt_s;

  mydesign_comb #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_dp (
    .a_i      (s1_r.a),
    .b_i      (s1_r.b),
    .result_o (dp_result_s)
  );

  // S1: capture the granted request's operands, or empty out on an idle advance.
  always_ff @(posedge clk_ci) begin
    if (rst_i) begin
      s1_valid_r <= 1'b0;
      s1_r       <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= gnt_valid_s;
      if (gnt_valid_s) begin
        s1_r.id <= gnt_idx_s;
        s1_r.a  <= req_a_i[gnt_idx_s*N_IN +: N_IN];
        s1_r.b  <= req_b_i[gnt_idx_s*N_IN +: N_IN];
      end else begin
        s1_r <= s1_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_r       <= s1_r;
    end
  end

  // S2: take the datapath result from S1; holds steady while the consumer stalls.
  always_ff @(posedge clk_ci) begin
    if (rst_i) begin
      s2_valid_r <= 1'b0;
      s2_r       <= '0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_r.id     <= s1_r.id;
        s2_r.result <= dp_result_s;
      end else begin
        s2_r <= s2_r;
      end
    end else begin
      s2_valid_r <= s2_valid_r;
      s2_r       <= s2_r;
    end
  end

  assign rsp_valid_o  = s2_valid_r;
  assign rsp_id_o     = s2_r.id;
  assign rsp_result_o = s2_r.result;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (default round-robin build).
// Operands are fixed per requester: r0 15*15=33, r1 7*9=63, r2 3*5=15,
// r3 6*11=2 (all mod 64).
module tb_mult_share_arbiter;

  logic        clk_ci;
  logic        rst_i;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [15:0] req_a_i;
  logic [15:0] req_b_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_id_o;
  logic [5:0]  rsp_result_o;

  int total;
  int bad;

  typedef struct {
    logic [3:0] vld;
    logic       rrdy;
    logic [3:0] rdy;
    logic       rv;
    logic [1:0] id;
    logic [5:0] res;
  } vec_t;

  vec_t vecs[18];

  mult_share_arbiter dut (
    .clk_ci       (clk_ci),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o)
  );

  initial clk_ci = 1'b0;
  always #5 clk_ci = ~clk_ci;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle after the falling edge, then check what the DUT shows.
  task automatic cyc(input string tag, input logic rst, input logic [3:0] vld,
                     input logic rrdy, input logic [3:0] erdy, input logic erv,
                     input logic [1:0] eid, input logic [5:0] eres);
    @(negedge clk_ci);
    rst_i       = rst;
    req_valid_i = vld;
    rsp_ready_i = rrdy;
    #1;
    chk({tag, " ready"}, 32'(req_ready_o), 32'(erdy));
    chk({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'(erv));
    if (erv) begin
      chk({tag, " rsp_id"}, 32'(rsp_id_o), 32'(eid));
      chk({tag, " rsp_result"}, 32'(rsp_result_o), 32'(eres));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_i       = 1'b1;
    req_valid_i = 4'b1111;
    rsp_ready_i = 1'b1;
    req_a_i     = {4'd6, 4'd3, 4'd7, 4'd15};
    req_b_i     = {4'd11, 4'd5, 4'd9, 4'd15};

    // Single op on r2, truncation on r0, then round-robin with staggered drops.
    vecs[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 6'd0};
    vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 6'd0};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 6'd15};
    vecs[3]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 6'd0};
    vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 6'd0};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 6'd33};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 6'd0};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0, 6'd0};
    vecs[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 6'd63};
    vecs[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 6'd15};
    vecs[10] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3, 6'd2};
    vecs[11] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 6'd33};
    vecs[12] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 2'd1, 6'd63};
    vecs[13] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd2, 6'd15};
    vecs[14] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd3, 6'd2};
    vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 6'd33};
    vecs[16] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 6'd63};
    vecs[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 6'd0};

    // Reset: no grants while held, outputs cleared.
    @(posedge clk_ci);
    cyc("reset", 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 6'd0);
    chk("reset rsp_id", 32'(rsp_id_o), 32'd0);
    chk("reset rsp_result", 32'(rsp_result_o), 32'd0);
    @(posedge clk_ci);

    for (int i = 0; i < 18; i++) begin
      cyc($sformatf("vec%0d", i), 1'b0, vecs[i].vld, vecs[i].rrdy,
          vecs[i].rdy, vecs[i].rv, vecs[i].id, vecs[i].res);
    end

    // Backpressure: pointer at 2; two accepts fill the pipe, then stall.
    cyc("bp0", 1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0, 2'd0, 6'd0);
    cyc("bp1", 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0, 2'd0, 6'd0);
    cyc("bp2", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 6'd15);
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("bp_hold%0d", i), 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 6'd15);
    end
    cyc("bp_rel0", 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 6'd15);
    cyc("bp_rel1", 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3, 6'd2);
    cyc("bp_rel2", 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 6'd33);
    cyc("bp_rel3", 1'b0, 4'b1011, 1'b1, 4'b1000, 1'b1, 2'd1, 6'd63);
    cyc("bp_rel4", 1'b0, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd2, 6'd15);
    cyc("bp_rel5", 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd3, 6'd2);
    cyc("bp_rel6", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 6'd33);
    cyc("bp_rel7", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 6'd63);
    cyc("bp_rel8", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 6'd0);

    // Reset mid-flight: r0 in S2, r1 in S1, then a one-cycle reset.
    cyc("mr0", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 6'd0);
    cyc("mr1", 1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd0, 6'd0);
    cyc("mr_rst", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 6'd33);
    cyc("mr_after", 1'b0, 4'b0110, 1'b1, 4'b0010, 1'b0, 2'd0, 6'd0);
    chk("mr_after rsp_id", 32'(rsp_id_o), 32'd0);
    chk("mr_after rsp_result", 32'(rsp_result_o), 32'd0);
    cyc("mr2", 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 6'd0);
    cyc("mr3", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 6'd63);
    cyc("mr4", 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 6'd15);
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("mr_idle%0d", i), 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 6'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
